fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 47 ++++
 rtl/fetch_buffer.sv | 111 +++++++++++
 tb/tb_fetch_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
// Constants and shared wire types for the fetch buffer: halfword realignment
// between the instruction fetch port and decode.
package fetch_buffer_const_pkg;

  localparam int FETCH_BUFFER_DEPTH = 8;
  // Pointer field width in buffer_reg_type; covers DEPTH up to 128.
  localparam int FB_PTR_W = 8;

endpackage

package fetch_buffer_pkg;

  import fetch_buffer_const_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        ready;
    logic        align;
    logic        clear;
    logic        stall;
  } buffer_in_type;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        done;
    logic        stall;
  } buffer_out_type;

  typedef struct packed {
    logic [FB_PTR_W-1:0] rptr;
    logic [FB_PTR_W-1:0] wptr;
    logic [FB_PTR_W:0]   count;
    logic [31:0]         head_pc;
    logic                first;
  } buffer_reg_type;

  localparam buffer_reg_type init_buffer_reg = '{
    rptr:    '0,
    wptr:    '0,
    count:   '0,
    head_pc: '0,
    first:   1'b1
  };

endpackage

// File: rtl/fetch_buffer.sv
// Circular halfword buffer that accepts 32-bit fetch words and presents
// 16-bit (compressed) or 32-bit instructions with their pc to decode.
module fetch_buffer
  import fetch_buffer_const_pkg::*;
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUFFER_DEPTH
) (
  input  logic           clock,
  input  logic           reset,
  input  buffer_in_type  buffer_in,
  output buffer_out_type buffer_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = FB_PTR_W + 1;

  typedef logic [AW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  logic [15:0]    mem_q [DEPTH];
  buffer_reg_type r_q, r_d;

  idx_t        rd_idx, wr_idx;
  logic [15:0] head_hw, next_hw;
  logic        head_comp, avail, consume;
  logic        first_align, wr_req, wr_room;
  logic [1:0]  consumed, written;
  cnt_t        free;
  logic        wr0_en, wr1_en;
  idx_t        wr0_idx, wr1_idx;
  logic [15:0] wr0_data;
  logic        unused_bits;

  assign rd_idx      = r_q.rptr[AW-1:0];
  assign wr_idx      = r_q.wptr[AW-1:0];
  assign unused_bits = ^{r_q.rptr[FB_PTR_W-1:AW], r_q.wptr[FB_PTR_W-1:AW],
                         buffer_in.pc[1:0]};

  // Head decode; the +1 index wraps naturally, which assembles a 32-bit
  // instruction that straddles slot DEPTH-1 and slot 0.
  always_comb begin
    head_hw   = mem_q[rd_idx];
    next_hw   = mem_q[rd_idx + idx_t'(1)];
    head_comp = (head_hw[1:0] != 2'b11);
    avail     = head_comp ? (r_q.count >= cnt_t'(1)) : (r_q.count >= cnt_t'(2));
    consume   = avail && !buffer_in.stall && !buffer_in.clear && !reset;
    consumed  = consume ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
  end

  // The first word after a flush may start mid-word and carry only its upper half.
  always_comb begin
    first_align = r_q.first && buffer_in.align;
    wr_req      = buffer_in.ready && !buffer_in.clear;
    free        = cnt_t'(DEPTH) - r_q.count;
    wr_room     = first_align ? (free >= cnt_t'(1)) : (free >= cnt_t'(2));
    written     = 2'd0;
    if (wr_req && wr_room) written = first_align ? 2'd1 : 2'd2;
    wr0_en   = (written != 2'd0);
    wr0_idx  = wr_idx;
    wr0_data = first_align ? buffer_in.rdata[31:16] : buffer_in.rdata[15:0];
    wr1_en   = (written == 2'd2);
    wr1_idx  = wr_idx + idx_t'(1);
  end

  // NOTE: every field of r_d is defaulted from r_q first, so no path through
  // this block leaves a field unassigned and no latch is inferred.
  always_comb begin
    r_d = r_q;
    if (buffer_in.clear) begin
      r_d = init_buffer_reg;
    end else begin
      r_d.rptr  = FB_PTR_W'(idx_t'(rd_idx + idx_t'(consumed)));
      r_d.wptr  = FB_PTR_W'(idx_t'(wr_idx + idx_t'(written)));
      r_d.count = r_q.count + cnt_t'(written) - cnt_t'(consumed);
      if (written != 2'd0 && r_q.first) begin
        r_d.head_pc = {buffer_in.pc[31:2], buffer_in.align, 1'b0};
        r_d.first   = 1'b0;
      end else begin
        r_d.head_pc = r_q.head_pc + 32'({consumed, 1'b0});
      end
    end
  end

  always_comb begin
    buffer_out.done  = consume;
    buffer_out.pc    = reset ? 32'h0 : r_q.head_pc;
    buffer_out.instr = 32'h0;
    if (!reset && avail) buffer_out.instr = head_comp ? {16'h0, head_hw} : {next_hw, head_hw};
    buffer_out.stall = !reset && (r_q.count > cnt_t'(DEPTH - 4));
  end

  always_ff @(posedge clock) begin
    if (reset) r_q <= init_buffer_reg;
    else       r_q <= r_d;
  end

  // NOTE: the halfword array is deliberately not reset; count and pointers
  // alone decide what is valid, so stale contents are never presented.
  always_ff @(posedge clock) begin
    if (wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (wr1_en) mem_q[wr1_idx] <= buffer_in.rdata[31:16];
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_req)
      assert (wr_room)
      else $error("fetch_buffer: incoming word dropped, not enough free slots");
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized bench for fetch_buffer against a halfword-queue
// reference model.
module tb_fetch_buffer;

  import fetch_buffer_const_pkg::*;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = FETCH_BUFFER_DEPTH;

  logic           clock = 1'b0;
  logic           reset;
  buffer_in_type  bin;
  buffer_out_type bout;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq [$];
  logic [31:0] m_pc;
  bit          m_first;
  bit          m_quiet;

  always #5 clock = ~clock;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .buffer_in  (bin),
    .buffer_out (bout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rdy, input logic [31:0] pc, input logic [31:0] data,
                       input bit aln, input bit clr, input bit stl);
    bin.ready = rdy;
    bin.pc    = pc;
    bin.rdata = data;
    bin.align = aln;
    bin.clear = clr;
    bin.stall = stl;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  // One clock cycle: compare outputs at the falling edge, advance the model
  // at the rising edge, return 1 time unit later ready for new inputs.
  task automatic cyc(input string tag, input bit chk, input bit e_done,
                     input logic [31:0] e_pc, input logic [31:0] e_instr);
    logic [31:0] x_instr;
    bit          x_avail, x_done, x_stall;
    int          n_pop, free;
    @(negedge clock);
    x_avail = 0;
    x_instr = '0;
    n_pop   = 0;
    if (mq.size() >= 1 && mq[0][1:0] != 2'b11) begin
      x_avail = 1; x_instr = {16'h0, mq[0]}; n_pop = 1;
    end else if (mq.size() >= 2) begin
      x_avail = 1; x_instr = {mq[1], mq[0]}; n_pop = 2;
    end
    x_done  = x_avail && !bin.stall && !bin.clear && !reset;
    x_stall = !reset && (mq.size() > DEPTH - 4);
    check({tag, ".done"}, 32'(bout.done), 32'(x_done));
    check({tag, ".stall"}, 32'(bout.stall), 32'(x_stall));
    if (reset || m_quiet) begin
      check({tag, ".pc0"}, bout.pc, 32'h0);
      check({tag, ".instr0"}, bout.instr, 32'h0);
    end else if (x_avail && !bin.clear) begin
      check({tag, ".pc"}, bout.pc, m_pc);
      check({tag, ".instr"}, bout.instr, x_instr);
    end
    if (chk) begin
      check({tag, ".dir_done"}, 32'(bout.done), 32'(e_done));
      if (e_done) begin
        check({tag, ".dir_pc"}, bout.pc, e_pc);
        check({tag, ".dir_instr"}, bout.instr, e_instr);
      end
    end
    free = DEPTH - mq.size();
    @(posedge clock);
    if (reset) begin
      mq.delete(); m_pc = '0; m_first = 1; m_quiet = 1;
    end else if (bin.clear) begin
      mq.delete(); m_first = 1; m_quiet = 0;
    end else begin
      if (x_done) begin
        repeat (n_pop) void'(mq.pop_front());
        m_pc += 32'(2 * n_pop);
      end
      if (bin.ready) begin
        if (m_first && bin.align) begin
          if (free >= 1) begin
            mq.push_back(bin.rdata[31:16]);
            m_pc = {bin.pc[31:2], 2'b10}; m_first = 0; m_quiet = 0;
          end
        end else if (free >= 2) begin
          mq.push_back(bin.rdata[15:0]);
          mq.push_back(bin.rdata[31:16]);
          if (m_first) begin
            m_pc = {bin.pc[31:2], 2'b00}; m_first = 0; m_quiet = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    cyc("rst", 1, 0, '0, '0);
    reset = 1'b0;
  endtask

  logic [31:0] fpc, data;
  bit          rst, clr, stl, rdy, aln;
  logic [31:0] wrap_words [5] = '{32'h00010001, 32'h00010001, 32'h00010001,
                                  32'h00130001, 32'h00010000};

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    mq.delete(); m_pc = '0; m_first = 1; m_quiet = 1;
    cyc("rst0", 1, 0, '0, '0);
    do_reset();

    // Aligned 32-bit stream
    drive(1, 32'h100, 32'h00000013, 0, 0, 0); cyc("a32_0", 1, 0, '0, '0);
    drive(1, 32'h104, 32'h00100093, 0, 0, 0); cyc("a32_1", 1, 1, 32'h100, 32'h00000013);
    drive(0, '0, '0, 0, 0, 0);                cyc("a32_2", 1, 1, 32'h104, 32'h00100093);
    cyc("a32_3", 1, 0, '0, '0);

    // Compressed pair
    do_reset();
    drive(1, 32'h200, 32'h00010001, 0, 0, 0); cyc("cp_0", 1, 0, '0, '0);
    drive(0, '0, '0, 0, 0, 0);                cyc("cp_1", 1, 1, 32'h200, 32'h00000001);
    cyc("cp_2", 1, 1, 32'h202, 32'h00000001);
    cyc("cp_3", 1, 0, '0, '0);

    // Misaligned 32-bit after a flush
    drive(0, '0, '0, 0, 1, 0);                cyc("mis_clr", 1, 0, '0, '0);
    drive(1, 32'h300, 32'h0013abcd, 1, 0, 0); cyc("mis_0", 1, 0, '0, '0);
    drive(1, 32'h304, 32'hffff0000, 0, 0, 0); cyc("mis_1", 1, 0, '0, '0);
    drive(0, '0, '0, 0, 0, 0);                cyc("mis_2", 1, 1, 32'h302, 32'h00000013);
    cyc("mis_3", 1, 0, '0, '0);
    drive(0, '0, '0, 0, 1, 0);                cyc("mis_clr2", 1, 0, '0, '0);

    // Backpressure: four words while decode is stalled, then drain in order
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h500 + 32'(4 * k), 32'h00010001, 0, 0, 1);
      cyc("bp_fill", 1, 0, '0, '0);
      check("bp_stall_out", 32'(bout.stall), 32'(k >= 2));
    end
    drive(0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc("bp_drain", 1, 1, 32'h500 + 32'(2 * k), 32'h00000001);
    cyc("bp_empty", 1, 0, '0, '0);

    // Flush with four halfwords buffered and a word arriving
    do_reset();
    drive(1, 32'h580, 32'h00010001, 0, 0, 1); cyc("fl_0", 1, 0, '0, '0);
    drive(1, 32'h584, 32'h00010001, 0, 0, 1); cyc("fl_1", 1, 0, '0, '0);
    drive(1, 32'h588, 32'h00010001, 0, 1, 0); cyc("fl_clr", 1, 0, '0, '0);
    drive(1, 32'h600, 32'h00000013, 0, 0, 0); cyc("fl_2", 1, 0, '0, '0);
    drive(0, '0, '0, 0, 0, 0);                cyc("fl_3", 1, 1, 32'h600, 32'h00000013);
    cyc("fl_4", 1, 0, '0, '0);

    // Reset mid-operation discards buffered halfwords
    drive(1, 32'h640, 32'h00010001, 0, 0, 1); cyc("mr_0", 1, 0, '0, '0);
    do_reset();
    drive(0, '0, '0, 0, 0, 0);
    cyc("mr_1", 1, 0, '0, '0);
    cyc("mr_2", 1, 0, '0, '0);

    // Wrap: 32-bit instruction in slots DEPTH-1 and 0
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 5) drive(1, 32'h700 + 32'(4 * i), wrap_words[i], 0, 0, 0);
      else       drive(0, '0, '0, 0, 0, 0);
      if (i == 0 || i == 10) cyc("wr", 1, 0, '0, '0);
      else if (i <= 7)       cyc("wr", 1, 1, 32'h700 + 32'(2 * (i - 1)), 32'h00000001);
      else if (i == 8)       cyc("wr_split", 1, 1, 32'h70e, 32'h00000013);
      else                   cyc("wr", 1, 1, 32'h712, 32'h00000001);
    end
    check("wr_stall_idle", 32'(bout.stall), 32'h0);

    // Randomized traffic against the model
    fpc = 32'h1000;
    for (int n = 0; n < 800; n++) begin
      rst  = ($urandom_range(199) == 0);
      clr  = !rst && ($urandom_range(24) == 0);
      stl  = ($urandom_range(2) == 0);
      rdy  = ($urandom_range(2) != 0) && (DEPTH - mq.size() >= 2);
      aln  = ($urandom_range(1) == 1);
      data = {rand_hw(), rand_hw()};
      reset = rst;
      drive(rdy, fpc, data, aln, clr, stl);
      if (rst || clr)  fpc = $urandom() & 32'hffff_fffc;
      else if (rdy)    fpc = fpc + 32'd4;
      cyc("rand", 0, 0, '0, '0);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
